// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable latency,
// byte-lane store steering, load sign/zero extension and fault detection.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  accept;
    logic                  access;
    logic                  a_write;
    logic [31:0]           a_addr;
    logic [2:0]            a_funct3;
    logic [31:0]           a_wdata;
    logic                  a_fault;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic [31:0]           rd_word;
    logic [31:0]           rd_lane;
    logic [31:0]           ld_data;
    logic [3:0]            st_be;
    logic [31:0]           st_data;

    assign accept = req_valid && req_ready;

    // The RAM access fires on the edge before RESP; with LATENCY==1 that is the
    // accept edge, so the live request fields are used instead of the captured ones.
    assign access = !reset && ((accept && (LATENCY == 1)) ||
                               (state_q == StBusy && cnt_q == 4'd1));

    // Select the request fields seen by the access logic.
    always_comb begin
        if (state_q == StIdle) begin
            a_write  = req_write;
            a_addr   = req_addr;
            a_funct3 = req_funct3;
            a_wdata  = req_wdata;
        end else begin
            a_write  = write_q;
            a_addr   = addr_q;
            a_funct3 = funct3_q;
            a_wdata  = wdata_q;
        end
    end

    assign a_idx = a_addr[ADDR_WIDTH+1:2];

    // Fault detection: illegal size, illegal store/load encodings, misalignment, range.
    always_comb begin
        a_fault = 1'b0;
        if (a_funct3[1:0] == 2'b11)                          a_fault = 1'b1;
        if (a_write && a_funct3[2])                          a_fault = 1'b1;
        if (!a_write && a_funct3[2:1] == 2'b11)              a_fault = 1'b1;
        if (a_funct3[1:0] == 2'b01 && a_addr[0])             a_fault = 1'b1;
        if (a_funct3[1:0] == 2'b10 && a_addr[1:0] != 2'b00)  a_fault = 1'b1;
        if ((a_addr >> (ADDR_WIDTH + 2)) != 32'd0)           a_fault = 1'b1;
    end

    // Load formatting: shift the addressed lane down, then extend by funct3.
    always_comb begin
        rd_word = mem[a_idx];
        rd_lane = rd_word >> {a_addr[1:0], 3'b000};
        case (a_funct3)
            3'b000:  ld_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
            3'b100:  ld_data = {24'd0, rd_lane[7:0]};
            3'b001:  ld_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
            3'b101:  ld_data = {16'd0, rd_lane[15:0]};
            3'b010:  ld_data = rd_word;
            default: ld_data = 32'd0;
        endcase
    end

    // Store steering: replicate data across lanes and enable only the addressed ones.
    always_comb begin
        case (a_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << a_addr[1:0];
                st_data = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = a_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{a_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = a_wdata;
            end
        endcase
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && a_write && !a_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[a_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    // State register, countdown, captured request and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= req_write;
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (access) begin
                rdata_q <= (a_fault || a_write) ? 32'd0 : ld_data;
                fault_q <= a_fault;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and the response registers.
    always_comb begin
        req_ready = (state_q == StIdle) && !reset;
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
        rsp_fault = fault_q;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RV32 core: it accepts one load or store request at a time from the core's memory port, adds a programmable access latency, and returns load data or a store acknowledgement. It holds a unified word-organised instruction/data RAM with byte-lane steering, load sign/zero extension and alignment/range fault detection. It sits between the core's address mux and backing storage, and is also the bench model for stall-tolerant controller work.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. The RAM holds 2^ADDR_WIDTH 32-bit words; the byte range is 0 .. 2^(ADDR_WIDTH+2)-1.
- `LATENCY`, default 2: cycles from request acceptance to response. Legal range is 1..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; equals (state==IDLE) && !reset.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_funct3`  in  3  RV32 load/store funct3 (size/sign).
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  formatted load data; 0 for stores and faults.
- `rsp_fault`  out  1  qualified by rsp_valid; misaligned, out-of-range or illegal funct3.

## Operation
- **States:**
  - IDLE: req_ready=1.
  - BUSY: latency countdown.
  - RESP: rsp_valid=1.
- **Accept:** when req_valid && req_ready in cycle t.
  - Register write, addr, funct3 and wdata.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY==1, else go to BUSY.
- **BUSY:** decrement the counter each cycle. When the counter is 1, next state is RESP. Request inputs are ignored.
- **RESP:** rsp_valid=1 for exactly one cycle, then IDLE. No request can be accepted in RESP.
- **Fault rules**, evaluated on the registered request:
  - funct3[1:0]==11.
  - Store with funct3[2]==1.
  - Load funct3 110 or 111.
  - Halfword with addr[0]!=0.
  - Word with addr[1:0]!=0.
  - addr[31:ADDR_WIDTH+2] != 0.
- **On fault:** no RAM write, rsp_rdata=0, rsp_fault=1.
- **Store byte enables:**
  - sb: lane addr[1:0] gets wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - sw: all four lanes.
  - Unselected lanes keep their contents.
- **Load formatting:** select the byte or halfword at addr[1:0].
  - 000 lb: sign-extend.
  - 100 lbu: zero-extend.
  - 001 lh: sign-extend.
  - 101 lhu: zero-extend.
  - 010 lw: whole word.
- **RAM:** contents are not affected by reset and power up undefined (the bench preloads them).

## Timing
- **Accept/response:** accept in cycle t; rsp_valid high in cycle t+LATENCY only.
- **RAM access:** the array read and the store commit happen on the edge ending cycle t+LATENCY-1.
  - rsp_rdata and rsp_fault are registered at that edge.
  - For LATENCY=1 this is the accept edge itself.
- **Throughput:** next accept is at the earliest in cycle t+LATENCY+1 (first IDLE cycle). Back-to-back throughput is one request per LATENCY+1 cycles.
- **Output hold:** rsp_rdata and rsp_fault hold their value until the next response update. Consumers sample them only with rsp_valid.
- **Request holding:** the requester holds its request fields only during the accept cycle; the responder never re-samples them.
- **Reset values:** state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0. req_ready=0 during the reset cycle and 1 the cycle after.
- **Reset mid-operation** (BUSY or RESP): the pending request is dropped, no response pulse occurs, and the RAM is unchanged. If the commit edge coincides with reset, the write is suppressed.
- **Load after store to the same address:** the load returns the newly stored data, because the store commits before the load can be accepted.
- **req_valid without req_ready:** no effect. The requester must keep req_valid asserted until accepted.

## Test plan
- **Word store/load, LATENCY=2:**
  - Stimulus: sw 0xDEADBEEF to 0x40, accepted in cycle 5; then lw 0x40.
  - Required: store rsp_valid in cycle 7 with rdata=0 and fault=0; next accept no earlier than cycle 8; lw response rdata=0xDEADBEEF.
- **Sub-word stores:**
  - Stimulus: word at 0x80 preloaded 0x11223344; sb 0xAA to 0x81; sh 0xBEEF to 0x82.
  - Required: lw 0x80 returns 0xBEEFAA44.
- **Sign/zero extension:**
  - Stimulus: word at 0x80 = 0xBEEFAA44.
  - Required: lb 0x81 returns 0xFFFFFFAA; lbu 0x81 returns 0x000000AA; lh 0x82 returns 0xFFFFBEEF; lhu 0x82 returns 0x0000BEEF.
- **Faults:**
  - Stimulus: lw 0x42, sh 0x43, funct3=011, and (ADDR_WIDTH=10) lw 0x1000.
  - Required: each gives rsp_fault=1 and rdata=0; a faulting sw to 0x42 leaves 0x40 unchanged.
- **LATENCY=1 and stall:**
  - Stimulus: req_valid held high continuously.
  - Required: accepts in cycles 1, 3, 5; rsp_valid in cycles 2, 4, 6; req_ready low in each response cycle.
- **Reset mid-op:**
  - Stimulus: LATENCY=3; sw 0x12345678 to 0x10 accepted in cycle 4 over an old value of 0; reset in cycle 5.
  - Required: no rsp_valid; req_ready=1 in cycle 6; lw 0x10 returns the old value 0.
